// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file write-destination codes and the
// write-back queue entry layout.
package cpu_pkg;

    localparam int unsigned DEST_W = 2;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [DEST_W-1:0] {
        WD_NONE = 2'b00,
        WD_RS   = 2'b01,
        WD_RT   = 2'b10,
        WD_R31  = 2'b11
    } wdest_e;

    localparam logic [REG_W-1:0] REG_RA = 5'd31;

    typedef struct packed {
        wdest_e              dest;
        logic [REG_W-1:0]    rnum;
        logic [DATA_W-1:0]   data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_HOLD
    } wb_state_e;

    // Code 11 always targets the return-address register.
    function automatic wb_entry_t make_entry(input logic [DEST_W-1:0] dest,
                                             input logic [REG_W-1:0]  rnum,
                                             input logic [DATA_W-1:0] data);
        wb_entry_t e;
        e.dest = wdest_e'(dest);
        e.rnum = (wdest_e'(dest) == WD_R31) ? REG_RA : rnum;
        e.data = data;
        return e;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular write-back queue: up to two pushes (a before b) and one pop per
// cycle, plus a newest-first associative search on register number.
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               push_a,
    input  wb_entry_t          entry_a,
    input  logic               push_b,
    input  wb_entry_t          entry_b,
    input  logic               pop,
    output wb_entry_t          head_c,
    output logic [CNT_W-1:0]   count,
    input  logic [REG_W-1:0]   srch_add,
    output logic               srch_hit_c,
    output logic [DATA_W-1:0]  srch_data_c
);

    wb_entry_t          mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   idx;
    wb_entry_t          wr_first;

    // A lone push_b lands in the first free slot.
    always_comb begin
        wr_first = push_a ? entry_a : entry_b;
    end

    always_ff @(posedge clk) begin
        if (!clear) begin
            if (push_a || push_b)
                mem[wr_ptr] <= wr_first;
            if (push_a && push_b)
                mem[wr_ptr + PTR_W'(1)] <= entry_b;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(push_a) + PTR_W'(push_b);
            rd_ptr <= rd_ptr + PTR_W'(pop);
            count  <= count + CNT_W'(push_a) + CNT_W'(push_b) - CNT_W'(pop);
        end
    end

    assign head_c = mem[rd_ptr];

    // Walk oldest to newest so the newest valid match is the one kept.
    always_comb begin
        srch_hit_c  = 1'b0;
        srch_data_c = '0;
        idx         = rd_ptr;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < count) && (mem[idx].rnum == srch_add)) begin
                srch_hit_c  = 1'b1;
                srch_data_c = mem[idx].data;
            end
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// Register-file write-side controller: queues ALU/load write-backs and issues
// one registered write per cycle, with stall, overflow and forwarding.
module reg_writeback
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               alu_valid,
    input  logic [DEST_W-1:0]  alu_dest,
    input  logic [REG_W-1:0]   alu_reg,
    input  logic [DATA_W-1:0]  alu_data,
    input  logic               ld_valid,
    input  logic [DEST_W-1:0]  ld_dest,
    input  logic [REG_W-1:0]   ld_reg,
    input  logic [DATA_W-1:0]  ld_data,
    input  logic               wb_hold,
    input  logic               flush,
    output logic [DEST_W-1:0]  w_dest,
    output logic [DATA_W-1:0]  reg_write_data,
    output logic [REG_W-1:0]   wb_reg,
    output logic               stall,
    output logic               ovf,
    input  logic [REG_W-1:0]   fwd_add,
    output logic               fwd_hit,
    output logic [DATA_W-1:0]  fwd_data
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    wb_state_e          state_q, state_d;
    wb_entry_t          out_q, out_d;
    wb_entry_t          head_c, ld_entry, alu_entry;
    logic [CNT_W-1:0]   count, free_c, cnt_next;
    logic               pop_c, ld_req, alu_req, ld_acc, alu_acc, drop_c;
    logic               stall_q, stall_d, ovf_q;
    logic               q_hit;
    logic [DATA_W-1:0]  q_data;

    assign ld_entry  = make_entry(ld_dest, ld_reg, ld_data);
    assign alu_entry = make_entry(alu_dest, alu_reg, alu_data);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .clear       (flush),
        .push_a      (ld_acc),
        .entry_a     (ld_entry),
        .push_b      (alu_acc),
        .entry_b     (alu_entry),
        .pop         (pop_c),
        .head_c      (head_c),
        .count       (count),
        .srch_add    (fwd_add),
        .srch_hit_c  (q_hit),
        .srch_data_c (q_data)
    );

    // Issue FSM: pick the next output entry from the pre-edge queue count.
    always_comb begin
        state_d = ST_IDLE;
        out_d   = '0;
        pop_c   = 1'b0;
        if (flush || (count == '0)) begin
            state_d = ST_IDLE;
        end else if (wb_hold) begin
            state_d = ST_HOLD;
        end else begin
            state_d = ST_ISSUE;
            out_d   = head_c;
            pop_c   = 1'b1;
        end
    end

    // Admission: the slot freed by this edge's pop is usable; load goes first.
    always_comb begin
        ld_req   = ld_valid  && (ld_dest  != WD_NONE);
        alu_req  = alu_valid && (alu_dest != WD_NONE);
        free_c   = CNT_W'(DEPTH) - count + CNT_W'(pop_c);
        ld_acc   = !flush && ld_req && (free_c != '0);
        alu_acc  = !flush && alu_req && (free_c > CNT_W'(ld_acc));
        drop_c   = !flush && ((ld_req && !ld_acc) || (alu_req && !alu_acc));
        cnt_next = flush ? '0
                         : count + CNT_W'(ld_acc) + CNT_W'(alu_acc) - CNT_W'(pop_c);
        stall_d  = cnt_next > CNT_W'(DEPTH - 2);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            stall_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            stall_q <= stall_d;
            ovf_q   <= ovf_q | drop_c;
        end
    end

    assign w_dest         = out_q.dest;
    assign reg_write_data = out_q.data;
    assign wb_reg         = out_q.rnum;
    assign stall          = stall_q;
    assign ovf            = ovf_q;

    // Queued entries are newer than the one on the outputs, so they win.
    always_comb begin
        fwd_hit  = q_hit;
        fwd_data = q_data;
        if (!q_hit && (state_q == ST_ISSUE) && (out_q.rnum == fwd_add)) begin
            fwd_hit  = 1'b1;
            fwd_data = out_q.data;
        end
    end

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback with a queue-based reference model.
module tb_reg_writeback;

    localparam int DEPTH = 4;

    logic        clk, rst;
    logic        alu_valid, ld_valid, wb_hold, flush;
    logic [1:0]  alu_dest, ld_dest;
    logic [4:0]  alu_reg, ld_reg, fwd_add;
    logic [31:0] alu_data, ld_data;
    logic [1:0]  w_dest;
    logic [31:0] reg_write_data, fwd_data;
    logic [4:0]  wb_reg;
    logic        stall, ovf, fwd_hit;

    int n_checks = 0;
    int n_err    = 0;

    reg_writeback #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_reg(alu_reg), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_dest(ld_dest), .ld_reg(ld_reg), .ld_data(ld_data),
        .wb_hold(wb_hold), .flush(flush),
        .w_dest(w_dest), .reg_write_data(reg_write_data), .wb_reg(wb_reg),
        .stall(stall), .ovf(ovf),
        .fwd_add(fwd_add), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending writes as an ordered list plus the write on the outputs.
    typedef struct {
        logic [1:0]  d;
        logic [4:0]  r;
        logic [31:0] v;
    } ment_t;

    ment_t q[$];
    ment_t m_out;
    logic  m_ovf, m_stall;

    function automatic ment_t mk(input logic [1:0] d, input logic [4:0] r, input logic [31:0] v);
        ment_t e;
        e.d = d;
        e.r = (d == 2'b11) ? 5'd31 : r;
        e.v = v;
        return e;
    endfunction

    function automatic ment_t none();
        ment_t e;
        e.d = 2'b00;
        e.r = 5'd0;
        e.v = 32'd0;
        return e;
    endfunction

    task automatic model_step();
        if (!rst) begin
            q.delete();
            m_out   = none();
            m_ovf   = 1'b0;
            m_stall = 1'b0;
        end else begin
            if (flush) begin
                q.delete();
                m_out = none();
            end else begin
                if (q.size() > 0 && !wb_hold) m_out = q.pop_front();
                else                          m_out = none();
                if (ld_valid && ld_dest != 2'b00) begin
                    if (q.size() < DEPTH) q.push_back(mk(ld_dest, ld_reg, ld_data));
                    else                  m_ovf = 1'b1;
                end
                if (alu_valid && alu_dest != 2'b00) begin
                    if (q.size() < DEPTH) q.push_back(mk(alu_dest, alu_reg, alu_data));
                    else                  m_ovf = 1'b1;
                end
            end
            m_stall = (DEPTH - q.size()) < 2;
        end
    endtask

    task automatic model_fwd(input logic [4:0] a, output logic h, output logic [31:0] d);
        h = 1'b0;
        d = 32'd0;
        if (m_out.d != 2'b00 && m_out.r == a) begin
            h = 1'b1;
            d = m_out.v;
        end
        foreach (q[i]) begin
            if (q[i].r == a) begin
                h = 1'b1;
                d = q[i].v;
            end
        end
    endtask

    initial begin
        m_out   = none();
        m_ovf   = 1'b0;
        m_stall = 1'b0;
        forever begin
            @(posedge clk or negedge rst);
            model_step();
        end
    end

    // Cycle-by-cycle compare, mid-cycle while the outputs are stable.
    initial begin
        logic        eh;
        logic [31:0] ed;
        forever begin
            @(negedge clk);
            if (rst) begin
                model_fwd(fwd_add, eh, ed);
                check("w_dest",   32'(w_dest),   32'(m_out.d));
                check("wb_reg",   32'(wb_reg),   32'(m_out.r));
                check("wr_data",  reg_write_data, m_out.v);
                check("stall",    32'(stall),    32'(m_stall));
                check("ovf",      32'(ovf),      32'(m_ovf));
                check("fwd_hit",  32'(fwd_hit),  32'(eh));
                check("fwd_data", fwd_data,      ed);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic no_req();
        alu_valid = 1'b0; alu_dest = 2'b00; alu_reg = 5'd0; alu_data = 32'd0;
        ld_valid  = 1'b0; ld_dest  = 2'b00; ld_reg  = 5'd0; ld_data  = 32'd0;
    endtask

    task automatic set_ld(input logic [1:0] d, input logic [4:0] r, input logic [31:0] v);
        ld_valid = 1'b1; ld_dest = d; ld_reg = r; ld_data = v;
    endtask

    task automatic set_alu(input logic [1:0] d, input logic [4:0] r, input logic [31:0] v);
        alu_valid = 1'b1; alu_dest = d; alu_reg = r; alu_data = v;
    endtask

    task automatic lit_out(input string name, input logic [1:0] d, input logic [4:0] r,
                           input logic [31:0] v);
        check({name, ".w_dest"}, 32'(w_dest), 32'(d));
        check({name, ".wb_reg"}, 32'(wb_reg), 32'(r));
        check({name, ".data"},   reg_write_data, v);
    endtask

    task automatic lit_fwd(input string name, input logic [4:0] a, input logic h,
                           input logic [31:0] v);
        fwd_add = a;
        #1;
        check({name, ".hit"},  32'(fwd_hit), 32'(h));
        check({name, ".data"}, fwd_data, v);
    endtask

    initial begin
        rst = 1'b1; wb_hold = 1'b0; flush = 1'b0; fwd_add = 5'd0;
        no_req();
        #1 rst = 1'b0;
        #2;
        lit_out("reset", 2'b00, 5'd0, 32'd0);
        check("reset.stall", 32'(stall), 32'd0);
        check("reset.ovf",   32'(ovf),   32'd0);
        check("reset.fwd",   32'(fwd_hit), 32'd0);
        repeat (2) cyc();
        rst = 1'b1;
        cyc();

        // Single ALU write: visible after the second edge, for one cycle.
        set_alu(2'b10, 5'd7, 32'hDEADBEEF);
        cyc(); no_req();
        lit_out("alu_lat0", 2'b00, 5'd0, 32'd0);
        cyc();
        lit_out("alu_issue", 2'b10, 5'd7, 32'hDEADBEEF);
        cyc();
        lit_out("alu_done", 2'b00, 5'd0, 32'd0);

        // Same-cycle load + ALU: load first, code 11 targets r31.
        set_ld(2'b01, 5'd3, 32'h11);
        set_alu(2'b11, 5'd5, 32'h22);
        cyc(); no_req();
        cyc(); lit_out("dual_ld", 2'b01, 5'd3, 32'h11);
        cyc(); lit_out("dual_alu", 2'b11, 5'd31, 32'h22);
        cyc(); lit_out("dual_idle", 2'b00, 5'd0, 32'd0);

        // Hold with two entries queued.
        wb_hold = 1'b1;
        set_ld(2'b01, 5'd3, 32'h11);
        set_alu(2'b11, 5'd5, 32'h22);
        cyc(); no_req();
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("hold.w_dest", 32'(w_dest), 32'd0);
            lit_fwd("hold.fwd3", 5'd3, 1'b1, 32'h11);
        end
        lit_fwd("hold.fwd31", 5'd31, 1'b1, 32'h22);
        wb_hold = 1'b0;
        cyc(); lit_out("hold_rel1", 2'b01, 5'd3, 32'h11);
        cyc(); lit_out("hold_rel2", 2'b11, 5'd31, 32'h22);
        cyc(); lit_out("hold_idle", 2'b00, 5'd0, 32'd0);

        // Fill under hold, overflow, pop+push on full, then flush.
        wb_hold = 1'b1;
        set_ld(2'b01, 5'd10, 32'h100);
        set_alu(2'b10, 5'd11, 32'h101);
        cyc(); no_req();
        check("fill2.stall", 32'(stall), 32'd0);
        set_ld(2'b01, 5'd12, 32'h102);
        cyc(); no_req();
        check("fill3.stall", 32'(stall), 32'd1);
        set_ld(2'b10, 5'd13, 32'h103);
        cyc(); no_req();
        check("fill4.stall", 32'(stall), 32'd1);
        check("fill4.ovf",   32'(ovf),   32'd0);
        set_ld(2'b01, 5'd14, 32'h104);
        cyc(); no_req();
        check("ovf.set", 32'(ovf), 32'd1);
        lit_fwd("ovf.lost", 5'd14, 1'b0, 32'd0);
        lit_fwd("ovf.kept", 5'd13, 1'b1, 32'h103);
        wb_hold = 1'b0;
        set_ld(2'b01, 5'd15, 32'h15);
        set_alu(2'b10, 5'd16, 32'h16);
        cyc(); no_req();
        lit_out("popfull", 2'b01, 5'd10, 32'h100);
        lit_fwd("popfull.ld",  5'd15, 1'b1, 32'h15);
        lit_fwd("popfull.alu", 5'd16, 1'b0, 32'd0);
        flush = 1'b1;
        set_ld(2'b01, 5'd17, 32'h17);
        cyc(); no_req();
        flush = 1'b0;
        lit_out("flush", 2'b00, 5'd0, 32'd0);
        check("flush.ovf",   32'(ovf),   32'd1);
        check("flush.stall", 32'(stall), 32'd0);
        lit_fwd("flush.drop", 5'd17, 1'b0, 32'd0);
        cyc(); lit_out("flush_idle", 2'b00, 5'd0, 32'd0);

        // Two writes to r9: newest data forwarded until both retire.
        wb_hold = 1'b1;
        set_ld(2'b01, 5'd9, 32'hA);
        set_alu(2'b10, 5'd9, 32'hB);
        cyc(); no_req();
        lit_fwd("r9.newest", 5'd9, 1'b1, 32'hB);
        wb_hold = 1'b0;
        cyc(); lit_out("r9.first", 2'b01, 5'd9, 32'hA);
        lit_fwd("r9.q", 5'd9, 1'b1, 32'hB);
        cyc(); lit_out("r9.second", 2'b10, 5'd9, 32'hB);
        lit_fwd("r9.out", 5'd9, 1'b1, 32'hB);
        cyc(); lit_fwd("r9.gone", 5'd9, 1'b0, 32'd0);

        // Asynchronous reset while a write is on the outputs.
        set_ld(2'b01, 5'd4, 32'h44);
        set_alu(2'b10, 5'd6, 32'h66);
        cyc(); no_req();
        cyc(); lit_out("rst.before", 2'b01, 5'd4, 32'h44);
        #1 rst = 1'b0;
        #1;
        lit_out("rst.now", 2'b00, 5'd0, 32'd0);
        check("rst.ovf", 32'(ovf), 32'd0);
        #3 rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            lit_out("rst.after", 2'b00, 5'd0, 32'd0);
        end
        lit_fwd("rst.fwd", 5'd6, 1'b0, 32'd0);

        repeat (2) cyc();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
